seq_parser_mc: RTL and testbench
================================

Name: seq_parser_mc

Overview:
- Multi-stream packet parser with per-stream sequence-gap detection.
- Takes 32-bit little-endian framed packets on a valid/ready/last stream and extracts the payload into a wide parallel word.
- Tracks the last sequence number per stream and flags lost packets, with a gap count.
- An output FIFO decouples ingress from the consumer, so ingress is not stalled while one packet waits to be read; malformed packets are reported, not silently dropped.

Parameters:
- MAX_PAYLOAD_BYTES, 37, largest payload byte count; dataOut width is MAX_PAYLOAD_BYTES*8.
- NUM_STREAMS, 32, number of tracked streams (power of two, >=2); SW=$clog2(NUM_STREAMS).
- OUT_DEPTH, 2, number of output FIFO entries (>=1).

Ports:
- clk  in  1  clock.
- reset_b  in  1  reset, synchronous, active-low.
- dataIn  in  32  ingress word; byte k is at dataIn[31-8k -: 8].
- dataIn_val  in  1  ingress word valid.
- dataIn_last  in  1  final word of the packet.
- dataIn_ready  out  1  ingress accept.
- dataOut  out  MAX_PAYLOAD_BYTES*8  payload; byte i at [W-1-8i -: 8]; unused bytes are 0.
- dataOut_bytes  out  16  payload byte count.
- dataOut_stream  out  16  stream id.
- dataOut_val  out  1  output valid.
- dataOut_ready  in  1  consumer accept.
- packetLost  out  1  sequence mismatch on a seen stream.
- gapCount  out  16  received seq minus expected seq (mod 2^32), saturated to 0xFFFF; 0 unless packetLost.
- formatError  out  1  packet malformed; dataOut is 0 and the sequence table is untouched.

Behaviour:
- Framing:
  - word0: length={byte1,byte0}, the total bytes including the 8-byte header; stream={byte3,byte2}.
  - word1: seq={byte3,byte2,byte1,byte0}.
  - Payload follows, packed MSB-first.
- A word transfers when dataIn_val & dataIn_ready.
- dataIn_ready = reset_b & (fifo count < OUT_DEPTH).
  - Registered count only; there is no combinational path from dataOut_ready.
- FSM states:
  - HDR0 -> HDR1 on a transfer. If last is asserted in HDR0, the packet is an error.
  - HDR1 -> DATA. If the packet ended in HDR1, the entry is committed immediately.
  - DATA -> HDR0 on a transfer with dataIn_last.
  - DRAIN: entered when payload bytes are exhausted without last; discards words until last.
- bytesLeft = length-8 is loaded in HDR0 and decremented by 4 per DATA word.
  - In the last word only min(bytesLeft,4) leading bytes are kept; the rest are zeroed.
- formatError is set when any of these holds:
  - length<8;
  - length>8+MAX_PAYLOAD_BYTES;
  - stream>=NUM_STREAMS;
  - last arrives with bytesLeft>4 or before HDR1 completes;
  - bytesLeft reaches 0 without last.
  - On error the whole packet is still consumed up to last, then one entry is pushed with formatError=1.
- Sequence check, done when the last word is accepted:
  - expected = seqTable[stream]+1, 32-bit wrap (0xFFFFFFFF -> 0).
  - If seen[stream]=0: packetLost=0 and seen is set.
  - Otherwise packetLost = (seq != expected).
  - seqTable[stream] is always set to seq on a good packet.
  - Back-to-back packets on the same stream must see the updated table (write-before-next-lookup).
- Latency: the last word accepted at cycle N gives dataOut_val at N+1 (FIFO was empty).
- Throughput: one word per cycle sustained when OUT_DEPTH>=2 and the consumer is always ready; the HDR0 of the next packet may transfer in the cycle after last.
- FIFO push and pop in the same cycle: count is unchanged. Pop happens when dataOut_val & dataOut_ready.
- All outputs are 0 when dataOut_val=0.
- Reset (including mid-packet): FSM->HDR0, FIFO empty, seen[] cleared, seqTable cleared, any partial packet discarded.
  - All outputs are 0 while reset_b=0.

Decomposition:
- Package seq_parser_pkg holds:
  - the state enum {HDR0,HDR1,DATA,DRAIN};
  - HDR_BYTES=8;
  - the typedef of the FIFO record {payload, bytes, stream, lost, gap, err};
  - the gap-saturation function.
- One sub-module, seq_parser_out_fifo: a parametrised synchronous FIFO of records, width and depth from parameters, exposing push, pop, count and head.

Test Plan:
- Stream 3, word0=0x2D000300 (length 45), word1=0x05000000 (seq 5), 10 payload words with last on word 10 -> dataOut_bytes=37, stream=3, packetLost=0, dataOut low 8 bits of the last byte lane exactly as sent and trailing 3 bytes of the last word zeroed, val at N+1.
- Same stream, next packet seq 6 then seq 9 -> packetLost=0 for seq 6; packetLost=1 with gapCount=2 for seq 9.
- Stream 7 seq 0xFFFFFFFF followed by seq 0 -> packetLost=0 (wrap). Then seq 0x00020000 -> gapCount=0xFFFF (saturated).
- dataOut_ready=0, three back-to-back packets with OUT_DEPTH=2 -> dataIn_ready drops after the 2nd last word; the 3rd packet's HDR0 stalls. Releasing ready drains the entries in order with no loss.
- length=0x0004, stream=40, and a packet with last arriving 2 words early -> each gives one entry with formatError=1 and dataOut=0; a subsequent valid packet on that stream is treated as first-seen.
- Assert reset_b=0 mid-DATA for 1 cycle, then send a fresh packet -> no partial entry is emitted; the fresh packet decodes correctly with packetLost=0.

Source files
------------

// File: rtl/seq_parser_pkg.sv
// Shared definitions for the multi-stream sequence parser.
//   - parserState_t : framing FSM states
//   - HDR_BYTES     : fixed header size counted inside the length field
//   - outRec_t      : one output FIFO entry (payload plus metadata)
//   - gapSat        : saturates a 32-bit sequence gap to 16 bits
package seq_parser_pkg;

    typedef enum logic [1:0] {
        HDR0,
        HDR1,
        DATA,
        DRAIN
    } parserState_t;

    localparam int HDR_BYTES = 8;

    // The record's payload field is sized by this constant, so the top-level
    // MAX_PAYLOAD_BYTES parameter must be kept equal to it.
    localparam int PKG_MAX_PAYLOAD_BYTES = 37;

    typedef struct packed {
        logic [PKG_MAX_PAYLOAD_BYTES*8-1:0] payload;
        logic [15:0]                        bytes;
        logic [15:0]                        stream;
        logic                               lost;
        logic [15:0]                        gap;
        logic                               err;
    } outRec_t;

    function automatic logic [15:0] gapSat(input logic [31:0] diff);
        return (diff > 32'h0000_FFFF) ? 16'hFFFF : diff[15:0];
    endfunction

endpackage

// File: rtl/seq_parser_out_fifo.sv
// Synchronous FIFO of fixed-width records.
// Ports:
//   clk, reset_b      clock and synchronous active-low reset
//   push, pushData    write request and record (ignored when full unless popping)
//   pop               read request (ignored when empty)
//   count             number of stored entries
//   head              oldest entry, valid whenever count != 0
module seq_parser_out_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset_b,
    input  logic                         push,
    input  logic [WIDTH-1:0]             pushData,
    input  logic                         pop,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [WIDTH-1:0]             head
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doPush;
    logic             doPop;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    // A push into a full FIFO is allowed only when a pop frees a slot in the same cycle.
    assign doPop  = pop && (count != '0);
    assign doPush = push && ((count != CNT_W'(DEPTH)) || doPop);
    assign head   = mem[rdPtr];

    // Record storage needs no reset; count decides what is valid.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= nextPtr(wrPtr);
            if (doPop)  rdPtr <= nextPtr(rdPtr);
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/seq_parser_mc.sv
// Multi-stream packet parser with per-stream sequence-gap detection.
// Ingress words are little-endian framed (length/stream, sequence, payload);
// each packet yields one FIFO entry holding the payload and its sequence status.
// Ports:
//   clk, reset_b                       clock, synchronous active-low reset
//   dataIn/_val/_last/_ready           ingress word stream
//   dataOut, dataOut_bytes/_stream     payload (MSB-first), byte count, stream id
//   dataOut_val/_ready                 output handshake
//   packetLost, gapCount, formatError  sequence status and malformed-packet flag
module seq_parser_mc
    import seq_parser_pkg::*;
#(
    parameter int MAX_PAYLOAD_BYTES = PKG_MAX_PAYLOAD_BYTES,
    parameter int NUM_STREAMS       = 32,
    parameter int OUT_DEPTH         = 2
) (
    input  logic                           clk,
    input  logic                           reset_b,
    input  logic [31:0]                    dataIn,
    input  logic                           dataIn_val,
    input  logic                           dataIn_last,
    output logic                           dataIn_ready,
    output logic [MAX_PAYLOAD_BYTES*8-1:0] dataOut,
    output logic [15:0]                    dataOut_bytes,
    output logic [15:0]                    dataOut_stream,
    output logic                           dataOut_val,
    input  logic                           dataOut_ready,
    output logic                           packetLost,
    output logic [15:0]                    gapCount,
    output logic                           formatError
);

    localparam int W     = MAX_PAYLOAD_BYTES * 8;
    localparam int SW    = $clog2(NUM_STREAMS);
    localparam int CNT_W = $clog2(OUT_DEPTH+1);

    parserState_t                   state;
    logic [15:0]                    curStream;
    logic [15:0]                    payLen;
    logic [15:0]                    bytesLeft;
    logic [15:0]                    byteIdx;
    logic [31:0]                    seqReg;
    logic [W-1:0]                   payload;
    logic [W-1:0]                   mergedPayload;
    logic [NUM_STREAMS-1:0][31:0]   seqTable;
    logic [NUM_STREAMS-1:0]         seen;

    logic                           xfer;
    logic [15:0]                    hdrLength;
    logic [15:0]                    hdrStream;
    logic [31:0]                    wordSeq;
    logic                           hdrBad;
    logic [2:0]                     keepBytes;
    logic [SW-1:0]                  tblIdx;
    logic                           commit;
    logic                           commitErr;
    logic [31:0]                    commitSeq;
    logic [31:0]                    expectedSeq;
    logic                           seqMismatch;
    outRec_t                        pushRec;
    outRec_t                        headRec;
    logic [$bits(outRec_t)-1:0]     fifoHead;
    logic [CNT_W-1:0]               fifoCount;

    // Ready depends only on registered occupancy, never on dataOut_ready.
    assign dataIn_ready = reset_b && (fifoCount < CNT_W'(OUT_DEPTH));
    assign xfer         = dataIn_val && dataIn_ready;

    // Byte k of the word sits at dataIn[31-8k -: 8]; header fields are little-endian.
    assign hdrLength = {dataIn[23:16], dataIn[31:24]};
    assign hdrStream = {dataIn[7:0],   dataIn[15:8]};
    assign wordSeq   = {dataIn[7:0], dataIn[15:8], dataIn[23:16], dataIn[31:24]};
    assign hdrBad    = (hdrLength < 16'(HDR_BYTES)) ||
                       (hdrLength > 16'(HDR_BYTES + MAX_PAYLOAD_BYTES)) ||
                       (hdrStream >= 16'(NUM_STREAMS));
    assign keepBytes = (bytesLeft >= 16'd4) ? 3'd4 : bytesLeft[2:0];
    assign tblIdx    = curStream[SW-1:0];

    // Each payload byte slot takes the lane at offset (slot - byteIdx) of the
    // current word when that offset falls within the bytes still owed; a slot
    // below byteIdx wraps to a large offset and keeps its old value.
    for (genvar i = 0; i < MAX_PAYLOAD_BYTES; i++) begin : gByte
        logic [15:0] rel;
        logic [7:0]  laneByte;
        assign rel = 16'(i) - byteIdx;
        always_comb begin
            case (rel[1:0])
                2'd0:    laneByte = dataIn[31:24];
                2'd1:    laneByte = dataIn[23:16];
                2'd2:    laneByte = dataIn[15:8];
                default: laneByte = dataIn[7:0];
            endcase
        end
        assign mergedPayload[W-1-8*i -: 8] = (rel < {13'd0, keepBytes}) ? laneByte
                                                                         : payload[W-1-8*i -: 8];
    end

    // Decide whether this cycle closes a packet and whether it was malformed.
    // A header problem already diverted the FSM into DRAIN, so every close
    // from DRAIN is an error.
    always_comb begin
        commit    = 1'b0;
        commitErr = 1'b0;
        commitSeq = seqReg;
        if (xfer && dataIn_last) begin
            commit = 1'b1;
            case (state)
                HDR0:    commitErr = 1'b1;
                HDR1: begin
                    commitErr = (bytesLeft != 16'd0);
                    commitSeq = wordSeq;
                end
                DATA:    commitErr = (bytesLeft > 16'd4);
                default: commitErr = 1'b1;
            endcase
        end
    end

    // Build the entry pushed on commit; errors carry no payload or sequence status.
    always_comb begin
        expectedSeq    = seqTable[tblIdx] + 32'd1;
        seqMismatch    = seen[tblIdx] && (commitSeq != expectedSeq);
        pushRec        = '0;
        pushRec.err    = commitErr;
        pushRec.stream = (state == HDR0) ? hdrStream : curStream;
        if (!commitErr) begin
            pushRec.payload = (state == DATA) ? mergedPayload : payload;
            pushRec.bytes   = payLen;
            pushRec.lost    = seqMismatch;
            pushRec.gap     = seqMismatch ? gapSat(commitSeq - expectedSeq) : 16'd0;
        end
    end

    // Framing FSM: capture the header, accumulate payload words, and drain
    // malformed packets up to their last word. Reset discards any partial packet.
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state     <= HDR0;
            curStream <= '0;
            payLen    <= '0;
            bytesLeft <= '0;
            byteIdx   <= '0;
            seqReg    <= '0;
            payload   <= '0;
        end else if (xfer) begin
            case (state)
                HDR0: begin
                    curStream <= hdrStream;
                    payLen    <= hdrLength - 16'(HDR_BYTES);
                    bytesLeft <= hdrLength - 16'(HDR_BYTES);
                    byteIdx   <= '0;
                    payload   <= '0;
                    if (dataIn_last) state <= HDR0;
                    else if (hdrBad) state <= DRAIN;
                    else             state <= HDR1;
                end
                HDR1: begin
                    seqReg <= wordSeq;
                    if (dataIn_last)               state <= HDR0;
                    else if (bytesLeft == 16'd0)   state <= DRAIN;
                    else                           state <= DATA;
                end
                DATA: begin
                    if (dataIn_last) begin
                        state <= HDR0;
                    end else if (bytesLeft <= 16'd4) begin
                        state <= DRAIN;
                    end else begin
                        bytesLeft <= bytesLeft - 16'd4;
                        byteIdx   <= byteIdx + 16'd4;
                        payload   <= mergedPayload;
                    end
                end
                default: begin
                    if (dataIn_last) state <= HDR0;
                end
            endcase
        end
    end

    // Per-stream sequence history, written on the commit edge so the next
    // packet of the same stream, at least two cycles later, sees it.
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            seen     <= '0;
            seqTable <= '0;
        end else if (commit && !commitErr) begin
            seen[tblIdx]     <= 1'b1;
            seqTable[tblIdx] <= commitSeq;
        end
    end

    seq_parser_out_fifo #(
        .WIDTH ($bits(outRec_t)),
        .DEPTH (OUT_DEPTH)
    ) uOutFifo (
        .clk      (clk),
        .reset_b  (reset_b),
        .push     (commit),
        .pushData (pushRec),
        .pop      (dataOut_val && dataOut_ready),
        .count    (fifoCount),
        .head     (fifoHead)
    );

    // Outputs are forced to zero whenever no entry is presented or reset is held.
    assign headRec        = fifoHead;
    assign dataOut_val    = reset_b && (fifoCount != '0);
    assign dataOut        = dataOut_val ? headRec.payload : '0;
    assign dataOut_bytes  = dataOut_val ? headRec.bytes   : '0;
    assign dataOut_stream = dataOut_val ? headRec.stream  : '0;
    assign packetLost     = dataOut_val && headRec.lost;
    assign gapCount       = dataOut_val ? headRec.gap     : '0;
    assign formatError    = dataOut_val && headRec.err;

endmodule

// File: tb/tb_seq_parser_mc.sv
// Directed self-checking bench for seq_parser_mc. Each packet's expected
// entry is computed by a small framing/sequence model and queued; entries
// are popped and compared when the DUT presents them.
module tb_seq_parser_mc;

    typedef struct {
        logic [295:0] payload;
        logic [15:0]  bytes;
        logic [15:0]  stream;
        logic         lost;
        logic [15:0]  gap;
        logic         err;
    } expRec_t;

    logic          clk;
    logic          reset_b;
    logic [31:0]   dataIn;
    logic          dataIn_val;
    logic          dataIn_last;
    logic          dataIn_ready;
    logic [295:0]  dataOut;
    logic [15:0]   dataOut_bytes;
    logic [15:0]   dataOut_stream;
    logic          dataOut_val;
    logic          dataOut_ready;
    logic          packetLost;
    logic [15:0]   gapCount;
    logic          formatError;

    int            vectors = 0;
    int            miscompares = 0;
    expRec_t       sbQ[$];
    logic [31:0]   pktWords[$];
    logic [31:0]   seqM [32];
    bit            seenM [32];

    seq_parser_mc dut (
        .clk            (clk),
        .reset_b        (reset_b),
        .dataIn         (dataIn),
        .dataIn_val     (dataIn_val),
        .dataIn_last    (dataIn_last),
        .dataIn_ready   (dataIn_ready),
        .dataOut        (dataOut),
        .dataOut_bytes  (dataOut_bytes),
        .dataOut_stream (dataOut_stream),
        .dataOut_val    (dataOut_val),
        .dataOut_ready  (dataOut_ready),
        .packetLost     (packetLost),
        .gapCount       (gapCount),
        .formatError    (formatError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case some wait escapes its bound.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cmp(input string tag, input logic [295:0] obs, input logic [295:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic buildPacket(input logic [15:0] len, input logic [15:0] strm,
                               input logic [31:0] seq, input int nPay, input logic [7:0] seed);
        pktWords.delete();
        pktWords.push_back({len[7:0], len[15:8], strm[7:0], strm[15:8]});
        pktWords.push_back({seq[7:0], seq[15:8], seq[23:16], seq[31:24]});
        for (int j = 0; j < nPay; j++) begin
            logic [7:0] b;
            b = seed + 8'(4*j);
            pktWords.push_back({b, b + 8'd1, b + 8'd2, b + 8'd3});
        end
    endtask

    // Presents one word from a negedge and returns at the negedge after it is taken.
    task automatic sendWord(input logic [31:0] w, input logic last);
        int waitCycles;
        waitCycles  = 0;
        dataIn      = w;
        dataIn_last = last;
        dataIn_val  = 1'b1;
        while (dataIn_ready !== 1'b1 && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        if (dataIn_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL ingressTimeout: observed ready=%0b expected 1", dataIn_ready);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        dataIn_val  = 1'b0;
        dataIn_last = 1'b0;
    endtask

    task automatic applyStimulus(input logic [15:0] len, input logic [15:0] strm,
                                 input logic [31:0] seq, input int nPay,
                                 input logic [7:0] seed, input bit checkLat);
        expRec_t     e;
        int          payLen;
        bit          bad;
        logic [31:0] expSeq;
        logic [31:0] diff;
        buildPacket(len, strm, seq, nPay, seed);
        payLen = int'(len) - 8;
        bad = (len < 16'd8) || (len > 16'd45) || (strm >= 16'd32);
        if (!bad) bad = (nPay != (payLen + 3) / 4);
        e.payload = '0;
        e.bytes   = '0;
        e.stream  = strm;
        e.lost    = 1'b0;
        e.gap     = '0;
        e.err     = bad;
        if (!bad) begin
            e.bytes = 16'(payLen);
            for (int i = 0; i < payLen; i++) e.payload[295-8*i -: 8] = seed + 8'(i);
            expSeq = seqM[strm[4:0]] + 32'd1;
            diff   = seq - expSeq;
            e.lost = seenM[strm[4:0]] && (seq != expSeq);
            if (e.lost) e.gap = (diff > 32'hFFFF) ? 16'hFFFF : diff[15:0];
            seenM[strm[4:0]] = 1'b1;
            seqM[strm[4:0]]  = seq;
        end
        sbQ.push_back(e);
        for (int w = 0; w < pktWords.size(); w++) sendWord(pktWords[w], w == pktWords.size() - 1);
        if (checkLat) cmp("latencyN+1", {295'd0, dataOut_val}, 296'd1);
    endtask

    task automatic checkOutput(input string tag);
        expRec_t e;
        int      waitCycles;
        waitCycles = 0;
        while (dataOut_val !== 1'b1 && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        cmp({tag, ".val"}, {295'd0, dataOut_val}, 296'd1);
        if (sbQ.size() == 0) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL %s.scoreboard: observed empty expected entry", tag);
            return;
        end
        e = sbQ.pop_front();
        cmp({tag, ".payload"}, dataOut, e.payload);
        cmp({tag, ".lastLane"}, {288'd0, dataOut[7:0]}, {288'd0, e.payload[7:0]});
        cmp({tag, ".err"}, {295'd0, formatError}, {295'd0, e.err});
        cmp({tag, ".lost"}, {295'd0, packetLost}, {295'd0, e.lost});
        cmp({tag, ".gap"}, {280'd0, gapCount}, {280'd0, e.gap});
        if (!e.err) begin
            cmp({tag, ".bytes"}, {280'd0, dataOut_bytes}, {280'd0, e.bytes});
            cmp({tag, ".stream"}, {280'd0, dataOut_stream}, {280'd0, e.stream});
        end
        dataOut_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dataOut_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            seqM[i]  = '0;
            seenM[i] = 1'b0;
        end
        reset_b       = 1'b0;
        dataIn        = '0;
        dataIn_val    = 1'b0;
        dataIn_last   = 1'b0;
        dataOut_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        cmp("rst.inReady", {295'd0, dataIn_ready}, 296'd0);
        cmp("rst.outVal", {295'd0, dataOut_val}, 296'd0);
        cmp("rst.dataOut", dataOut, 296'd0);
        reset_b = 1'b1;
        @(negedge clk);
        cmp("idle.inReady", {295'd0, dataIn_ready}, 296'd1);

        // Full-size payload on stream 3, then in-order and gapped sequences
        applyStimulus(16'd45, 16'd3, 32'd5, 10, 8'h10, 1'b1);
        checkOutput("s3seq5");
        applyStimulus(16'd12, 16'd3, 32'd6, 1, 8'h40, 1'b0);
        checkOutput("s3seq6");
        applyStimulus(16'd12, 16'd3, 32'd9, 1, 8'h50, 1'b0);
        checkOutput("s3seq9gap");

        // Header-only packets on stream 7: wrap and saturated gap
        applyStimulus(16'd8, 16'd7, 32'hFFFF_FFFF, 0, 8'h00, 1'b0);
        checkOutput("s7seqMax");
        applyStimulus(16'd8, 16'd7, 32'h0000_0000, 0, 8'h00, 1'b0);
        checkOutput("s7wrap");
        applyStimulus(16'd8, 16'd7, 32'h0002_0000, 0, 8'h00, 1'b0);
        checkOutput("s7sat");

        // Back-pressure: two entries fill the FIFO, the third header must stall
        applyStimulus(16'd16, 16'd1, 32'd10, 2, 8'h60, 1'b0);
        applyStimulus(16'd16, 16'd1, 32'd11, 2, 8'h70, 1'b0);
        buildPacket(16'd16, 16'd1, 32'd12, 2, 8'h80);
        dataIn     = pktWords[0];
        dataIn_val = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cmp("stall.inReady", {295'd0, dataIn_ready}, 296'd0);
            @(negedge clk);
        end
        dataIn_val = 1'b0;
        checkOutput("stallP1");
        applyStimulus(16'd16, 16'd1, 32'd12, 2, 8'h80, 1'b0);
        checkOutput("stallP2");
        checkOutput("stallP3");

        // Malformed packets, then a first-seen packet on the same stream
        applyStimulus(16'd4, 16'd40, 32'd1, 0, 8'h00, 1'b0);
        checkOutput("errLenStream");
        applyStimulus(16'd46, 16'd2, 32'd1, 10, 8'h90, 1'b0);
        checkOutput("errTooLong");
        applyStimulus(16'd45, 16'd9, 32'd3, 8, 8'hA0, 1'b0);
        checkOutput("errEarlyLast");
        applyStimulus(16'd12, 16'd9, 32'd4, 2, 8'hB0, 1'b0);
        checkOutput("errNoLast");
        applyStimulus(16'd12, 16'd9, 32'd50, 1, 8'hC0, 1'b0);
        checkOutput("s9firstSeen");

        // Reset with one entry pending and a packet stopped mid-payload
        applyStimulus(16'd12, 16'd5, 32'd1, 1, 8'hD0, 1'b0);
        buildPacket(16'd45, 16'd3, 32'd10, 10, 8'hE0);
        for (int w = 0; w < 4; w++) sendWord(pktWords[w], 1'b0);
        reset_b = 1'b0;
        #1;
        cmp("midRst.outVal", {295'd0, dataOut_val}, 296'd0);
        cmp("midRst.inReady", {295'd0, dataIn_ready}, 296'd0);
        cmp("midRst.err", {295'd0, formatError}, 296'd0);
        @(negedge clk);
        reset_b = 1'b1;
        sbQ.delete();
        for (int i = 0; i < 32; i++) begin
            seqM[i]  = '0;
            seenM[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        cmp("postRst.outVal", {295'd0, dataOut_val}, 296'd0);
        applyStimulus(16'd45, 16'd3, 32'd77, 10, 8'h21, 1'b1);
        checkOutput("postRstFresh");

        repeat (3) @(negedge clk);
        cmp("final.outVal", {295'd0, dataOut_val}, 296'd0);
        cmp("final.scoreboard", 296'(sbQ.size()), 296'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
